// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch-stage pipeline sequencer: state encoding,
// default address width and the redirect alignment check.
package fetch_ctrl_pkg;

   localparam int MEM_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      FC_RUN    = 2'd0,
      FC_STALL  = 2'd1,
      FC_DRAIN  = 2'd2,
      FC_HALTED = 2'd3
   } fc_state_e;

   function automatic logic tgt_misaligned(input logic [1:0] tgt_lsb);
      return tgt_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds once it reaches all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != {WIDTH{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates redirect, load-use stall and halt, and
// drives PC/IF-ID/ID-EX controls combinationally from state and inputs.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
   parameter int LU_STALL     = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  br_taken,
   input  logic [ADDR_WIDTH-1:0] br_tgt,
   input  logic                  lu_hazard,
   input  logic                  halt_req,
   input  logic                  resume,
   output logic                  pc_en,
   output logic                  stall_en,
   output logic                  jmp_bch_en,
   output logic [ADDR_WIDTH-1:0] jmp_bch_tgt,
   output logic                  ifid_en,
   output logic                  idex_flush,
   output logic                  halted,
   output logic                  misalign_err,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [CNT_WIDTH-1:0]  flush_cnt,
   output fc_state_e             state_dbg
);

   localparam logic [2:0] LU_LOAD    = 3'(LU_STALL - 1);
   localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

   fc_state_e  state;
   logic [2:0] cnt;
   logic       redirect;
   logic       freeze;

   assign state_dbg = state;

   // HALTED ignores every event source, including redirects.
   assign redirect = rst_n && br_taken && (state != FC_HALTED);
   assign freeze   = rst_n && !br_taken &&
                     (((state == FC_RUN) && lu_hazard) || (state == FC_STALL));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= FC_RUN;
         cnt          <= '0;
         misalign_err <= 1'b0;
      end else begin
         if (redirect && tgt_misaligned(br_tgt[1:0]))
            misalign_err <= 1'b1;
         case (state)
            FC_RUN: begin
               if (br_taken) begin
                  cnt <= '0;
               end else if (lu_hazard) begin
                  if (LU_STALL > 1) begin
                     state <= FC_STALL;
                     cnt   <= LU_LOAD;
                  end
               end else if (halt_req) begin
                  state <= FC_DRAIN;
                  cnt   <= DRAIN_LOAD;
               end
            end
            FC_STALL, FC_DRAIN: begin
               if (br_taken) begin
                  state <= FC_RUN;
                  cnt   <= '0;
               end else if (cnt <= 3'd1) begin
                  state <= (state == FC_STALL) ? FC_RUN : FC_HALTED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            FC_HALTED: begin
               if (resume)
                  state <= FC_RUN;
            end
            default: begin
               state <= FC_RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      pc_en      = 1'b1;
      stall_en   = 1'b0;
      ifid_en    = 1'b1;
      idex_flush = 1'b0;
      jmp_bch_en = 1'b0;
      halted     = 1'b0;
      if (!rst_n) begin
         pc_en      = 1'b0;
         stall_en   = 1'b1;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (redirect) begin
         // Squash the wrong-path fetch and the wrong-path ID instruction.
         jmp_bch_en = 1'b1;
         stall_en   = 1'b1;
         idex_flush = 1'b1;
      end else if (freeze) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (state == FC_DRAIN) begin
         pc_en      = 1'b0;
         stall_en   = 1'b1;
         idex_flush = 1'b1;
      end else if (state == FC_HALTED) begin
         pc_en      = 1'b0;
         stall_en   = 1'b1;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         halted     = 1'b1;
      end
   end

   assign jmp_bch_tgt = jmp_bch_en ? br_tgt : '0;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (freeze),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (redirect),
      .count (flush_cnt)
   );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Pipeline-control sequencer that drives the instruction-fetch stage's control inputs: PC enable, NOP-injection stall, and jump/branch redirect with target.
- Also drives the IF/ID register enable and the ID/EX bubble.
- Arbitrates three event sources: EX-stage taken branch/jump, ID-stage load-use hazard, and ID-stage halt request (ECALL/EBREAK).
- Sits between the hazard/branch logic and stage_IF plus the IF/ID and ID/EX pipeline registers.

Parameters:
- ADDR_WIDTH, `MEM_ADDR_WIDTH, width of PC and branch target.
- LU_STALL, 1, cycles frozen per load-use hazard (1..7).
- DRAIN_CYCLES, 3, cycles to retire in-flight instructions before halting (1..7).
- CNT_WIDTH, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- br_taken  in  1  EX stage resolved a taken branch or jump this cycle.
- br_tgt  in  ADDR_WIDTH  redirect target, valid with br_taken.
- lu_hazard  in  1  ID holds a consumer of the load in EX.
- halt_req  in  1  ID holds ECALL/EBREAK.
- resume  in  1  single-cycle pulse leaving HALTED.
- pc_en  out  1  to stage_IF pc_en.
- stall_en  out  1  to stage_IF stall_en (inject NOP into IF/ID).
- jmp_bch_en  out  1  to stage_IF jmp_bch_en.
- jmp_bch_tgt  out  ADDR_WIDTH  to stage_IF jmp_bch_tgt.
- ifid_en  out  1  IF/ID register load enable.
- idex_flush  out  1  replace ID/EX contents with bubble.
- halted  out  1  core quiescent.
- misalign_err  out  1  sticky: a redirect target had tgt[1:0] != 0.
- stall_cnt  out  CNT_WIDTH  load-use stall cycles, saturating.
- flush_cnt  out  CNT_WIDTH  redirects taken, saturating.

Behaviour:
- States: RUN, STALL, DRAIN, HALTED. A 3-bit down-counter cnt is shared by STALL and DRAIN.
- Reset (rst_n=0 at edge): state=RUN, cnt=0, counters=0, misalign_err=0.
- Output decode during reset cycles: pc_en=0, stall_en=1, ifid_en=0, idex_flush=1, jmp_bch_en=0, jmp_bch_tgt=0, halted=0. Reset mid-STALL or mid-DRAIN aborts immediately.
- Outputs are combinational from state plus inputs (Mealy) so a redirect acts in the same cycle it is requested.
- jmp_bch_tgt = br_tgt whenever jmp_bch_en=1, else 0.
- Priority, evaluated every non-reset cycle in every state except HALTED: br_taken > lu_hazard > halt_req.
- RUN, idle: pc_en=1, ifid_en=1, stall_en=0, idex_flush=0.
- Redirect (br_taken=1 in RUN, STALL or DRAIN):
  - jmp_bch_en=1, pc_en=1, ifid_en=1, stall_en=1 (wrong-path fetch squashed), idex_flush=1 (wrong-path ID instruction killed).
  - Next state RUN, cnt=0.
  - flush_cnt+1 saturating at all-ones.
  - misalign_err set if br_tgt[1:0]!=0; redirect still performed.
  - A pending stall or drain is abandoned because the triggering instruction was on the wrong path.
- Load-use (RUN, lu_hazard=1, no br_taken):
  - pc_en=0, ifid_en=0, idex_flush=1, stall_en=0.
  - If LU_STALL=1 stay RUN; else go to STALL with cnt=LU_STALL-1.
  - stall_cnt+1 per frozen cycle, including this one.
- STALL: same outputs as the load-use cycle; cnt decrements each cycle; at cnt==1 next state RUN. lu_hazard is ignored while in STALL.
- Halt (RUN, halt_req=1, no br_taken, no lu_hazard):
  - Go to DRAIN with cnt=DRAIN_CYCLES.
  - Outputs this cycle are as in RUN, so the halt instruction advances to EX.
- DRAIN: pc_en=0, stall_en=1, ifid_en=1 (NOPs fill IF/ID), idex_flush=1. cnt decrements each cycle; at cnt==1 next state HALTED.
- HALTED: pc_en=0, stall_en=1, ifid_en=0, idex_flush=1, halted=1. br_taken, lu_hazard and halt_req are ignored. resume=1 goes to RUN next cycle with PC unchanged (still the address after the halt instruction).
- Simultaneous lu_hazard and halt_req: lu_hazard wins; halt_req is re-sampled after the stall.
- Counter saturation: a counter at all-ones holds.

Decomposition:
- Shared constants file constants.vh gains state encodings FC_RUN=2'd0, FC_STALL=2'd1, FC_DRAIN=2'd2, FC_HALTED=2'd3 and the NOP encoding 32'h00000013.
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rst_n, inc; output count), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset then release, no events -> first cycle after release pc_en=1, stall_en=0, ifid_en=1, halted=0; stall_cnt=flush_cnt=0.
- br_taken=1, br_tgt=0x40 in RUN -> same cycle jmp_bch_en=1, jmp_bch_tgt=0x40, stall_en=1, idex_flush=1; flush_cnt=1; misalign_err=0.
- LU_STALL=2, lu_hazard for 1 cycle -> pc_en=0 for exactly 2 cycles, then 1; stall_cnt=2.
- halt_req with DRAIN_CYCLES=3 -> RUN outputs for 1 cycle, 3 DRAIN cycles, then halted=1 held; resume pulse -> pc_en=1 next cycle, halted=0.
- br_taken=1 together with lu_hazard and halt_req, and separately br_taken during the 2nd DRAIN cycle -> redirect taken, returns to RUN, halted never asserts; br_tgt=0x42 sets misalign_err.
- 65535 redirects with CNT_WIDTH=16, then one more -> flush_cnt holds at 0xFFFF; asserting rst_n=0 mid-STALL -> counters cleared, state RUN.
